// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encoding, FSM states and default width for the mul/div unit
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_datapath.sv
// rtl/muldiv_datapath.sv - unsigned iterative core: shift-add multiply and restoring divide
// One shared adder serves both the multiply add and the divide trial subtract.
module muldiv_datapath #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   ld_dvs,
  input  logic [XLEN-1:0]   ld_quo,
  output logic [2*XLEN-1:0] acc_nxt,
  output logic [XLEN-1:0]   quo_nxt
);

  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   dvs;
  logic [XLEN-1:0]   quo;

  logic [XLEN:0]   r_sh;
  logic [XLEN:0]   lhs;
  logic [XLEN:0]   rhs;
  logic [XLEN+1:0] sum;
  logic            no_borrow;

  always_comb begin
    r_sh      = {acc[XLEN-1:0], quo[XLEN-1]};
    lhs       = is_div ? r_sh : {1'b0, acc[2*XLEN-1:XLEN]};
    rhs       = is_div ? ~{1'b0, dvs} : (quo[0] ? {1'b0, dvs} : '0);
    sum       = {1'b0, lhs} + {1'b0, rhs} + {{(XLEN+1){1'b0}}, is_div};
    no_borrow = sum[XLEN+1];
    if (is_div) begin
      // Partial remainder lives in the low half; the dividend shifts out of quo MSB-first.
      acc_nxt = {{XLEN{1'b0}}, (no_borrow ? sum[XLEN-1:0] : r_sh[XLEN-1:0])};
      quo_nxt = {quo[XLEN-2:0], no_borrow};
    end else begin
      acc_nxt = {sum[XLEN:0], acc[XLEN-1:1]};
      quo_nxt = {1'b0, quo[XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      dvs <= '0;
      quo <= '0;
    end else if (load) begin
      acc <= '0;
      dvs <= ld_dvs;
      quo <= ld_quo;
    end else if (step) begin
      acc <= acc_nxt;
      quo <= quo_nxt;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - RV32M multiply/divide unit: control FSM and sign correction
// Operands are reduced to magnitudes on accept; signs are re-applied as the result is captured.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN      = XLEN_DEFAULT,
  parameter bit FAST_ZERO = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  state_t          state;
  logic [CW-1:0]   count;
  logic [2:0]      op_q;
  logic            sa_q, sb_q, bz_q;

  logic            a_sgn, b_sgn, sa, sb, accept;
  logic [XLEN-1:0] a_mag, b_mag, fz_result;
  logic [2*XLEN-1:0] acc_nxt, prod;
  logic [XLEN-1:0] quo_nxt, quo_res, rem_res, final_result;

  always_comb begin
    a_sgn = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
            (op == OP_DIV) || (op == OP_REM);
    b_sgn = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    sa    = a_sgn & a[XLEN-1];
    sb    = b_sgn & b[XLEN-1];
    a_mag = sa ? -a : a;
    b_mag = sb ? -b : b;
    accept    = (state == ST_IDLE) && start && !flush;
    fz_result = op[1] ? a : '1;
  end

  muldiv_datapath #(.XLEN(XLEN)) u_datapath (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .step    ((state == ST_CALC) && !flush),
    .is_div  (op_q[2]),
    .ld_dvs  (op[2] ? b_mag : a_mag),
    .ld_quo  (op[2] ? a_mag : b_mag),
    .acc_nxt (acc_nxt),
    .quo_nxt (quo_nxt)
  );

  // Evaluated on the final iteration, so uses the datapath's next-state values.
  always_comb begin
    prod    = (sa_q ^ sb_q) ? -acc_nxt : acc_nxt;
    quo_res = bz_q ? '1 : ((sa_q ^ sb_q) ? -quo_nxt : quo_nxt);
    rem_res = sa_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    case (op_q)
      OP_MUL:                 final_result = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU,
      OP_MULHU:               final_result = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:        final_result = quo_res;
      default:                final_result = rem_res;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      count  <= '0;
      op_q   <= '0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      bz_q   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else if (flush) begin
      state <= ST_IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q  <= op;
            sa_q  <= sa;
            sb_q  <= sb;
            bz_q  <= (b == '0);
            count <= '0;
            busy  <= 1'b1;
            if (FAST_ZERO && op[2] && (b == '0)) begin
              state  <= ST_DONE;
              done   <= 1'b1;
              result <= fz_result;
            end else begin
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          count <= count + CW'(1);
          if (count == CW'(XLEN - 1)) begin
            state  <= ST_DONE;
            done   <= 1'b1;
            result <= final_result;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        flush = 1'b0;
  logic        busy, done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  muldiv_unit #(.XLEN(32), .FAST_ZERO(1'b1)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    logic        ovf;
    logic [31:0] r;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      OP_MUL:    begin p = {{32{x[31]}}, x} * {{32{y[31]}}, y}; r = p[31:0];  end
      OP_MULH:   begin p = {{32{x[31]}}, x} * {{32{y[31]}}, y}; r = p[63:32]; end
      OP_MULHSU: begin p = {{32{x[31]}}, x} * {32'd0, y};       r = p[63:32]; end
      OP_MULHU:  begin p = {32'd0, x} * {32'd0, y};             r = p[63:32]; end
      OP_DIV:    r = (y == 0) ? 32'hFFFF_FFFF : ovf ? x : 32'($signed(x) / $signed(y));
      OP_DIVU:   r = (y == 0) ? 32'hFFFF_FFFF : x / y;
      OP_REM:    r = (y == 0) ? x : ovf ? 32'd0 : 32'($signed(x) % $signed(y));
      default:   r = (y == 0) ? x : x % y;
    endcase
    return r;
  endfunction

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] r, output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    lat = 1; bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    if (busy) bcnt++;
    r = result;
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("idle_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] r, ra, rb, exp_r;
    logic [2:0]  ro;
    int lat, bcnt, dn;

    vecs[0]  = '{OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vecs[1]  = '{OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vecs[2]  = '{OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 33};
    vecs[3]  = '{OP_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33};
    vecs[4]  = '{OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
    vecs[5]  = '{OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
    vecs[6]  = '{OP_DIVU,   32'd100,        32'd7,         32'd14,        33};
    vecs[7]  = '{OP_REMU,   32'd100,        32'd7,         32'd2,         33};
    vecs[8]  = '{OP_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{OP_REM,    32'd5,          32'd0,         32'd5,         1};
    vecs[10] = '{OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 33};
    vecs[11] = '{OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         33};
    vecs[12] = '{OP_REM,    32'hFFFF_FFF0,  32'd0,         32'hFFFF_FFF0, 1};
    vecs[13] = '{OP_DIVU,   32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 33};

    repeat (2) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, lat, bcnt);
      check($sformatf("vec%0d_result", i), r, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'(vecs[i].lat));
    end

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      exp_r = model(ro, ra, rb);
      run_op(ro, ra, rb, r, lat, bcnt);
      check($sformatf("rand%0d_op%0d_result", i, ro), r, exp_r);
      check($sformatf("rand%0d_latency", i), 32'(lat), (ro[2] && rb == 0) ? 32'd1 : 32'd33);
    end

    // Flush at CALC cycle 10 leaves the previous result intact.
    run_op(OP_MUL, 32'd3, 32'd5, r, lat, bcnt);
    check("pre_flush_result", r, 32'd15);
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_done", {31'd0, done}, 32'd0);
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dn++;
    end
    check("flush_no_done", 32'(dn), 32'd0);
    check("flush_result_kept", result, 32'd15);

    // start held through the whole operation, operands changed mid-flight.
    @(negedge clk);
    start = 1'b1; op = OP_MULHU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    @(negedge clk);
    a = 32'd1; b = 32'd1;
    dn = 0; r = 32'd0;
    repeat (80) begin
      if (done) begin
        dn++;
        r = result;
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("held_start_done_count", 32'(dn), 32'd1);
    check("held_start_result", r, 32'hFFFF_FFFE);

    // Asynchronous reset at CALC cycle 20, checked between clock edges.
    run_op(OP_MUL, 32'd7, 32'd9, r, lat, bcnt);
    check("pre_reset_result", r, 32'd63);
    @(negedge clk);
    start = 1'b1; op = OP_MUL; a = 32'd11; b = 32'd13;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_reset_busy", {31'd0, busy}, 32'd0);
    check("async_reset_done", {31'd0, done}, 32'd0);
    check("async_reset_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_op(OP_MUL, 32'd3, 32'd4, r, lat, bcnt);
    check("post_reset_result", r, 32'd12);
    check("post_reset_latency", 32'(lat), 32'd33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32, SHALL set operand and result width; it SHALL be at least 8 and even.
REQ-002 Parameter FAST_ZERO, default 1, SHALL enable a one-cycle early completion for divide-by-zero.
REQ-003 Port clk, input, 1: the single clock; all state SHALL change on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port start, input, 1: request; it SHALL be accepted only in IDLE.
REQ-006 Port op, input, 3: RV32M funct3 encoding, as follows.
- 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU.
- 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 Port a, input, XLEN: rs1 operand, sampled on accept.
REQ-008 Port b, input, XLEN: rs2 operand, sampled on accept.
REQ-009 Port flush, input, 1: aborts the operation in flight, from EX-stage branch or flush logic.
REQ-010 Port busy, output, 1: high in CALC and DONE; the pipeline uses it as the EX stall.
REQ-011 Port done, output, 1: one-cycle pulse marking result valid.
REQ-012 Port result, output, XLEN: the selected product or quotient word.

Function
REQ-013 The FSM SHALL have the states IDLE, CALC and DONE.
REQ-014 In IDLE, start=1 with flush=0 SHALL latch op, |a| and |b| (the magnitudes), and the sign flags, then enter CALC with count=0.
REQ-015 CALC SHALL perform one iteration per cycle and advance to DONE after exactly XLEN iterations.
- Multiply: shift-add on a 2*XLEN accumulator.
- Divide: restoring, one quotient bit per cycle.
REQ-016 DONE SHALL last exactly one cycle with done=1, then return to IDLE; done latency is XLEN+1 cycles after accept (33 at default).
REQ-017 Multiply signedness: MUL and MULH treat both operands as signed; MULHSU treats a as signed and b as unsigned; MULHU treats both as unsigned.
REQ-018 Multiply result: MUL returns the low XLEN bits; the MULH variants return the high XLEN bits of the sign-corrected 2*XLEN product.
REQ-019 DIV and REM SHALL be signed, with the quotient truncated toward zero and the remainder taking the sign of the dividend.
REQ-020 DIVU and REMU SHALL be unsigned.
REQ-021 Divide by zero SHALL return quotient all-ones and remainder a.
- FAST_ZERO=1: CALC is skipped and done is high 1 cycle after accept.
- FAST_ZERO=0: normal latency.
REQ-022 Signed overflow (a = most-negative value, b = -1) SHALL return DIV = a and REM = 0 at normal latency.
REQ-023 result SHALL update only on entry to DONE and SHALL hold until the next DONE.
REQ-024 start while busy SHALL be ignored, with no queueing.
REQ-025 When flush=1 in any state, the FSM SHALL go to IDLE at the next edge with no done pulse; result SHALL be unchanged.
REQ-026 When flush=1 and start=1 in the same IDLE cycle, the FSM SHALL not accept.
REQ-027 done and busy SHALL be registered outputs, with no combinational path from inputs.

Reset
REQ-028 When rst is asserted, the following SHALL hold asynchronously, regardless of mid-operation state:
- state = IDLE;
- busy = 0, done = 0;
- result = 0;
- count = 0;
- accumulators cleared.
REQ-029 The first start after rst deasserts SHALL be accepted normally.

Structure
REQ-030 A shared package SHALL hold:
- the op encoding constants;
- the FSM state enum;
- the default XLEN.
REQ-031 One sub-module, muldiv_datapath, SHALL hold:
- the accumulator, divisor and quotient registers;
- the per-cycle add/subtract step.
The FSM and sign correction SHALL stay in muldiv_unit.

Verification
REQ-032 MUL a=7, b=0xFFFFFFFD -> result=0xFFFFFFEB; done exactly 33 cycles after accept; busy high 33 cycles.
REQ-033 MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU a=0xFFFFFFFF, b=2 -> 0xFFFFFFFF.
REQ-034 DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU a=100, b=7 -> 14; REMU -> 2.
REQ-035 DIV a=5, b=0 -> 0xFFFFFFFF with done 1 cycle after accept; REM a=5, b=0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0.
REQ-036 Abort and ignore cases:
- flush at CALC cycle 10 -> IDLE next cycle, no done, result unchanged.
- start held during busy -> no second done.
REQ-037 rst pulse at CALC cycle 20 -> busy=0, done=0, result=0 immediately, without waiting for a clock edge; a following MUL 3*4 -> 12.
